// File: rtl/hd_swap_controller.sv
// Program swap sequencer: optional RAM->HD save of the current slot, then HD->RAM load of the new slot.
// Outputs are registered and precomputed from next-state values, so they line up with the state they describe.
module hd_swap_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int IDX_WIDTH  = 4,
    parameter int PROG_SIZE  = 150,
    parameter int NUM_PROGS  = 8,
    parameter int HD_BASE    = 200,
    parameter int RAM_BASE   = 550
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  save_en,
    input  logic [IDX_WIDTH-1:0]  cur_index,
    input  logic [IDX_WIDTH-1:0]  new_index,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_stall,
    output logic                  dir,
    output logic [ADDR_WIDTH-1:0] hd_addr,
    output logic                  hd_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we
);

    localparam int CNT_W = $clog2(PROG_SIZE + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PROG_SIZE);
    localparam logic [ADDR_WIDTH-1:0] RAM_BASE_A = ADDR_WIDTH'(RAM_BASE);

    typedef enum logic [1:0] {IDLE, SAVE, LOAD, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] cur_base, cur_base_nxt;
    logic [ADDR_WIDTH-1:0] new_base, new_base_nxt;
    logic                  err_nxt;

    logic                  busy_d, done_d, dir_d, hd_we_d, ram_we_d;
    logic [ADDR_WIDTH-1:0] hd_addr_d, ram_addr_d;
    logic [ADDR_WIDTH-1:0] cnt_a, cnt_prev_a;

    // Slot base wraps modulo 2^ADDR_WIDTH by construction.
    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [IDX_WIDTH-1:0] idx);
        return ADDR_WIDTH'(HD_BASE) + ADDR_WIDTH'(idx) * ADDR_WIDTH'(PROG_SIZE);
    endfunction

    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_base_nxt = cur_base;
        new_base_nxt = new_base;
        err_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if ((32'(new_index) >= NUM_PROGS) ||
                        (save_en && (32'(cur_index) >= NUM_PROGS))) begin
                        err_nxt = 1'b1;
                    end else begin
                        cur_base_nxt = slot_base(cur_index);
                        new_base_nxt = slot_base(new_index);
                        cnt_nxt      = '0;
                        state_nxt    = save_en ? SAVE : LOAD;
                    end
                end
            end
            SAVE: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOAD: begin
                if (cnt == CNT_LAST) state_nxt = DONE;
                else                 cnt_nxt   = cnt + 1'b1;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory reads are synchronous, so the write side trails the read side by one address.
    always_comb begin
        cnt_a      = ADDR_WIDTH'(cnt_nxt);
        cnt_prev_a = (cnt_nxt == '0) ? cnt_a : cnt_a - 1'b1;
        busy_d     = (state_nxt != IDLE);
        done_d     = (state_nxt == DONE);
        dir_d      = 1'b0;
        hd_we_d    = 1'b0;
        ram_we_d   = 1'b0;
        hd_addr_d  = '0;
        ram_addr_d = '0;
        unique case (state_nxt)
            SAVE: begin
                dir_d      = 1'b1;
                ram_addr_d = RAM_BASE_A + cnt_a;
                hd_we_d    = (cnt_nxt != '0);
                hd_addr_d  = cur_base_nxt + cnt_prev_a;
            end
            LOAD: begin
                hd_addr_d  = new_base_nxt + cnt_a;
                ram_we_d   = (cnt_nxt != '0);
                ram_addr_d = RAM_BASE_A + cnt_prev_a;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_base  <= '0;
            new_base  <= '0;
            busy      <= 1'b0;
            cpu_stall <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b0;
            hd_we     <= 1'b0;
            ram_we    <= 1'b0;
            hd_addr   <= '0;
            ram_addr  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_base  <= cur_base_nxt;
            new_base  <= new_base_nxt;
            busy      <= busy_d;
            cpu_stall <= busy_d;
            done      <= done_d;
            err       <= err_nxt;
            dir       <= dir_d;
            hd_we     <= hd_we_d;
            ram_we    <= ram_we_d;
            hd_addr   <= hd_addr_d;
            ram_addr  <= ram_addr_d;
        end
    end

endmodule

// File: doc/hd_swap_controller.md
# hd_swap_controller

Sequences a program swap between the HD and the RAM program region. On request, it first copies the RAM program region back to the current program's HD slot (optional save phase), then copies the new program's HD slot into RAM (load phase). It drives the address, write-enable and direction controls for both memories and stalls the CPU for the duration. It sits between the OS/dispatch logic and the HD/RAM ports, and replaces free-running load sequencing with a bounded, handshaked transfer.

## Interface
- ADDR_WIDTH, 12, width of HD and RAM addresses
- IDX_WIDTH, 4, width of program index inputs
- PROG_SIZE, 150, words per program slot, also words transferred per phase
- NUM_PROGS, 8, number of valid HD program slots
- HD_BASE, 200, HD address of slot 0
- RAM_BASE, 550, first RAM address of the program region

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  swap request, sampled only in IDLE
- save_en  in  1  when 1, run the save phase before the load phase
- cur_index  in  IDX_WIDTH  HD slot that receives the saved RAM image
- new_index  in  IDX_WIDTH  HD slot to load into RAM
- busy  out  1  high from the first cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse in DONE
- err  out  1  one-cycle pulse when start is rejected
- cpu_stall  out  1  equals busy
- dir  out  1  0 = HD→RAM (load), 1 = RAM→HD (save)
- hd_addr  out  ADDR_WIDTH  HD address (read in load, write in save)
- hd_we  out  1  HD write enable
- ram_addr  out  ADDR_WIDTH  RAM address (read in save, write in load)
- ram_we  out  1  RAM write enable

## Operation
- States: IDLE, SAVE, LOAD, DONE. There is a phase counter `cnt` that runs from 0 to PROG_SIZE.
- IDLE, start=1:
  - If cur_index or new_index is ≥ NUM_PROGS (cur_index is checked only when save_en=1), pulse err and stay in IDLE.
  - Otherwise latch both indices and save_en, clear cnt, and go to SAVE if save_en=1, else to LOAD.
- Slot base: slot(i) = HD_BASE + i·PROG_SIZE. Compute it at ADDR_WIDTH bits; overflow wraps modulo 2^ADDR_WIDTH with no error.
- Both memories have a 1-cycle synchronous read, so writes lag reads by one cycle.
- SAVE, cycle cnt=c:
  - dir=1.
  - ram_addr = RAM_BASE+c, used as a read for c<PROG_SIZE.
  - hd_we = (c≥1).
  - hd_addr = slot(cur)+c−1 when c≥1, else slot(cur).
  - ram_we=0.
  - At c=PROG_SIZE, go to LOAD and clear cnt.
- LOAD, cycle cnt=c:
  - dir=0.
  - hd_addr = slot(new)+c, used as a read for c<PROG_SIZE.
  - ram_we = (c≥1).
  - ram_addr = RAM_BASE+c−1 when c≥1, else RAM_BASE.
  - hd_we=0.
  - At c=PROG_SIZE, go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- start while busy is ignored; there is no queueing. Input index changes while busy have no effect.
- Reset mid-transfer: return to IDLE immediately. Partially written RAM/HD contents are left as is and are not rolled back.

## Timing
- Reset values: busy, done, err, cpu_stall, dir, hd_we, ram_we = 0; hd_addr = ram_addr = 0. In IDLE all outputs hold these values.
- All outputs are decoded from registered state, cnt and the latched indices only. There is no combinational path from any input to any output except err, which is registered (it pulses in the cycle after the rejected start).
- Latency:
  - start sampled at edge t → first SAVE/LOAD cycle begins at t.
  - Each phase lasts PROG_SIZE+1 cycles; DONE lasts 1 cycle.
  - busy cycles: 2·PROG_SIZE+3 with save, PROG_SIZE+2 without.
- Exactly PROG_SIZE write strobes per phase, to contiguous ascending addresses.
- A start held high through DONE is accepted again in the first IDLE cycle.

## Test plan
- Reset during idle, then release → all outputs 0; no write strobes for 20 cycles.
- Load only: start, save_en=0, new_index=2 → hd_addr reads 500..649; ram_we on RAM 550..699 one cycle later; 150 ram_we pulses; busy=152 cycles; done pulses once; hd_we never asserted.
- Save+load: cur=1, new=3, save_en=1 → HD writes 350..499 (150 pulses, dir=1), then HD reads 650..799 and RAM writes 550..699; busy=303 cycles; ram_we and hd_we are never high together.
- Rejection: new_index=8 (or cur_index=9 with save_en=1) → err=1 for one cycle, busy stays 0, no strobes. The same request with save_en=0 and valid new_index is accepted.
- Reset asserted at LOAD cnt=40 → outputs 0 in the same cycle (asynchronous); after release, state is IDLE and a new start runs a full 152-cycle load.
- start pulses at SAVE cnt=10 and in DONE → ignored; held start after DONE → second swap begins on the next IDLE cycle.
